// File: rtl/jtcps2_keystream.sv
// CPS2 decryption-key byte assembler. Collects KEYBYTES bytes from the
// downloader strobe, keeps a signature checksum and flags completion/overrun.
module jtcps2_keystream #(
  parameter int               KEYBYTES = 20,
  parameter int               SUMW     = 12,
  parameter logic [7:0]       SUM_MASK = 8'hCF,
  parameter logic [SUMW-1:0]  SUM_XOR  = 'h065
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              din,
  input  logic                    din_we,
  input  logic                    clr,
  input  logic [SUMW-1:0]         sum_ref,
  output logic [8*KEYBYTES-1:0]   data,
  output logic [7:0]              cnt,
  output logic                    busy,
  output logic                    done,
  output logic [SUMW-1:0]         sum,
  output logic                    sum_ok,
  output logic                    err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;
  localparam logic [7:0] KB8    = 8'(KEYBYTES);

  logic [1:0]            state_q, state_d;
  logic [8*KEYBYTES-1:0] data_q, data_d, shifted;
  logic [7:0]            cnt_q, cnt_d;
  logic [SUMW-1:0]       sum_q, sum_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  sum_ok_q, sum_ok_d, err_q, err_d;
  logic                  last_we_q;
  logic                  take;

  // Conditional XOR, then add the byte as a signed quantity.
  function automatic logic [SUMW-1:0] sum_step(input logic [SUMW-1:0] s,
                                               input logic [7:0] b);
    logic [SUMW-1:0] t;
    t = ((b & SUM_MASK) != 8'd0) ? (s ^ SUM_XOR) : s;
    return t + SUMW'($signed(b));
  endfunction

  assign take = din_we && !last_we_q;

  if (KEYBYTES == 1) begin : g_one
    assign shifted = din;
  end else begin : g_many
    assign shifted = {din, data_q[8*KEYBYTES-1:8]};
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    if (clr) begin
      state_d = S_IDLE;
      data_d  = '0;
      cnt_d   = '0;
      sum_d   = '0;
    end else if (take) begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          data_d  = shifted;
          cnt_d   = cnt_q + 8'd1;
          sum_d   = sum_step(sum_q, din);
          state_d = (cnt_q + 8'd1 == KB8) ? S_DONE : S_LOAD;
        end
        S_DONE:  state_d = S_ERR;
        default: state_d = state_q;
      endcase
    end
    // Flags follow the next state so they line up with the updated data.
    busy_d   = (state_d == S_LOAD);
    done_d   = (state_d == S_DONE);
    err_d    = (state_d == S_ERR);
    sum_ok_d = (state_d == S_DONE) && (sum_d == sum_ref);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_ok_q  <= 1'b0;
      err_q     <= 1'b0;
      last_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sum_ok_q  <= sum_ok_d;
      err_q     <= err_d;
      last_we_q <= din_we;
    end
  end

  assign data   = data_q;
  assign cnt    = cnt_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sum    = sum_q;
  assign sum_ok = sum_ok_q;
  assign err    = err_q;

endmodule

// File: doc/jtcps2_keystream.md
Name: jtcps2_keystream

Overview:
- Parametrised successor to the CPS2 key loader.
- Receives the decryption-key byte stream from the ROM downloader, one byte per rising edge of a write strobe, and assembles it into a KEYBYTES-wide vector.
- Keeps a running signature checksum, compares it against a supplied reference, and reports load progress, completion and overrun.
- The key-bit permutation stays in the downstream wrapper; this block delivers bytes in arrival order.

Parameters:
KEYBYTES, 20, number of key bytes in one load (legal 1..255)
SUMW, 12, checksum width in bits
SUM_MASK, 8'hCF, byte mask selecting when the XOR term applies
SUM_XOR, 12'h065, value XORed into the sum when (din & SUM_MASK) != 0

Ports:
clk      input   1              system clock
rst      input   1              synchronous reset, active high
din      input   8              key byte
din_we   input   1              write strobe; a byte is taken on its rising edge
clr      input   1              synchronous restart of a load
sum_ref  input   SUMW           expected checksum for the current game
data     output  8*KEYBYTES     assembled key; first byte received at [7:0]
cnt      output  8              bytes accepted in the current load
busy     output  1              load in progress (1..KEYBYTES-1 bytes taken)
done     output  1              exactly KEYBYTES bytes taken, no overrun
sum      output  SUMW           running checksum
sum_ok   output  1              done && sum==sum_ref
err      output  1              overrun: more than KEYBYTES bytes received

Behaviour:
- One clock, clk. rst is synchronous and active high. All outputs are registered.
- Reset values: data=0, cnt=0, sum=0, busy=0, done=0, sum_ok=0, err=0, last_we=0, state=IDLE.
- Edge detect:
  - last_we <= din_we every cycle except under rst.
  - A byte is accepted in any cycle where din_we && !last_we.
  - din_we already high on the first cycle after rst counts as an edge, because last_we=0.
- On an accepted byte in IDLE or LOAD:
  - data <= {din, data[8*KEYBYTES-1:8]}, i.e. shift in from the top. After KEYBYTES bytes the first byte sits at [7:0].
  - cnt <= cnt+1.
  - sum <= (((din & SUM_MASK) != 0) ? sum ^ SUM_XOR : sum) + sign_extend(din, SUMW), modulo 2^SUMW.
- FSM:
  - IDLE -> LOAD on the first accepted byte. If KEYBYTES==1 it goes straight to DONE.
  - LOAD -> DONE on the byte that makes cnt==KEYBYTES.
  - DONE -> ERR on any further accepted byte.
  - ERR is held until clr or rst.
- Output flags:
  - busy=1 only in LOAD.
  - done=1 only in DONE, asserted in the cycle after the last byte's edge cycle (1-cycle latency).
  - sum_ok is registered as (next state is DONE) && (next sum == sum_ref). It is valid in the same cycle done rises.
  - sum_ok re-evaluates every cycle while in DONE, so a sum_ref change is reflected one cycle later.
- ERR behaviour:
  - On entering ERR: err=1, done=0, sum_ok=0.
  - data, sum and cnt are frozen; cnt saturates at KEYBYTES.
  - Further edges are ignored.
- clr:
  - Returns every output and the state to its reset value, except last_we, which keeps tracking din_we.
  - clr takes priority over a simultaneous accepted byte; that byte is dropped.
- rst mid-load has the same effect as clr, and additionally last_we is cleared.
- An edge in the same cycle as state-entry is handled normally, with no bubble.
- Consecutive edges need din_we low for at least one cycle between them. A strobe held high is a single byte.

Test Plan:
- rst, then single byte 0x30 -> sum=0x030, cnt=1, busy=1, data[8*KEYBYTES-1 -: 8]=0x30, done=0.
- rst, then single byte 0x80 -> sum=(0x000^0x065)+0xF80=0xFE5. A second byte 0x01 -> sum=(0xFE5^0x065)+0x001=0xF81.
- Load 20 bytes 0x01..0x14 with sum_ref set to the bench model's checksum:
  - data[7:0]=0x01, data[159:152]=0x14.
  - done and sum_ok both rise one cycle after the 20th edge; busy=0; cnt=20.
  - Repeat with sum_ref+1 -> done=1, sum_ok=0.
- After done, send a 21st byte -> err=1, done=0, sum_ok=0, data/sum/cnt unchanged. A further edge is also ignored.
- Mid-load at cnt=7, assert clr in the same cycle as a rising din_we -> byte dropped; cnt=0, sum=0, data=0, state IDLE. The next edge is accepted as byte 1.
- din_we held high across a 4-cycle rst pulse, then held high for 10 cycles -> exactly one byte accepted after reset release. Also check a KEYBYTES=1 build: done=1 one cycle after the first edge.
